countdown_timer: RTL and testbench
==================================

# countdown_timer

Loadable down-counting timer. It is the consuming counterpart of the free-running 32-bit up-counter. The up-counter produces time; this block is programmed with an interval, counts it down, and signals expiry, in one-shot or periodic mode. It sits beside the up-counter in the timing subsystem and drives interrupt or event logic through a single-cycle `expired` pulse.

## Interface
- `WIDTH`, 32: counter and load width.
- `MAX_VALUE`, 2147483647: largest programmable interval. Loads above it are clamped to it, matching the up-counter wrap value.
- `EXP_CNT_W`, 16: width of the expiry event counter.

Ports:
- `clock`, in, 1: the only clock; everything is on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `load_valid`, in, 1: a new interval is offered on `load_value`.
- `load_value`, in, WIDTH: interval in clock cycles.
- `load_ready`, out, 1: the load is accepted when `load_valid && load_ready`.
- `start`, in, 1: level-sampled request to begin or resume counting.
- `stop`, in, 1: level-sampled request to pause counting.
- `periodic`, in, 1: mode select, latched when a start is accepted (0 = one-shot, 1 = periodic).
- `count`, out, WIDTH: current remaining count (registered).
- `expired`, out, 1: one-cycle pulse on each expiry.
- `busy`, out, 1: high while in RUN.
- `expire_count`, out, EXP_CNT_W: number of expiries since the last accepted load; saturates.

## Operation
- Internal registers: state, `reload` (WIDTH), `mode`.
- States:
  - IDLE: nothing loaded.
  - ARMED: loaded, `count` = `reload`.
  - RUN: counting.
  - PAUSED: stopped, `count` held.
  - DONE: one-shot finished.
- `load_ready` = 1 in every state except RUN.
- On load accept:
  - `reload` and `count` <= min(`load_value`, `MAX_VALUE`).
  - `expire_count` <= 0.
  - State <= ARMED.
  - Any `start` in the same cycle is ignored.
- ARMED/DONE + `start` (no load): `count` <= `reload`, `mode` <= `periodic`, state <= RUN.
- PAUSED + `start`: resume from the held `count`; `mode` is re-latched from `periodic`.
- IDLE + `start`: ignored.
- RUN + `stop`: state <= PAUSED, `count` held. `stop` has priority over decrement and expiry in the same cycle.
- RUN, `count` > 1: `count` <= `count` - 1.
- RUN, `count` == 1 (expiry):
  - `expired` <= 1 and `expire_count` increments.
  - If `mode` = 0: `count` <= 0, state <= DONE.
  - If `mode` = 1: `count` <= `reload`, stay in RUN.
- RUN, `count` == 0 (only possible with `reload` = 0):
  - `expired` <= 1 and `expire_count` increments.
  - State <= DONE regardless of `mode`.
  - Periodic mode with a zero interval is therefore forbidden in effect.
- `expire_count` holds at its all-ones value and never wraps.
- `start` and `stop` asserted together in RUN: `stop` wins.
- In states other than RUN, `stop` has no effect.

## Timing
- Reset values:
  - State IDLE, `count` = 0, `reload` = 0, `mode` = 0.
  - `expired` = 0, `busy` = 0, `load_ready` = 1, `expire_count` = 0.
- Reset acts immediately on assertion, even mid-RUN. The pending expiry is lost.
- Outputs are registered except `load_ready` and `busy`, which are decoded directly from state.
- Start accepted at edge k with interval N ≥ 1:
  - `count` = N after edge k.
  - `expired` is high for the cycle after edge k+N.
- Periodic mode: `expired` pulses every N cycles, with no gap cycle at reload.
- Interval N = 0: `expired` is high after edge k+1 and the block is in DONE.
- Pause/resume: total cycles spent in RUN before expiry still equals N.

## Test plan
- Reset mid-count:
  - Load 10, start, assert `reset_n`=0 at cycle 4.
  - Outputs go to reset values asynchronously; no `expired`.
- One-shot:
  - Load 5, start with `periodic`=0.
  - `count` runs 5,4,3,2,1,0; `expired` pulses once, 5 cycles after start.
  - Ends in DONE with `busy`=0 and `expire_count`=1.
- Periodic:
  - Load 3, start with `periodic`=1, run 10 cycles.
  - `expired` at cycles 3, 6, 9; `count` sequence 3,2,1,3,2,1,...
  - `expire_count`=3 after cycle 10.
- Pause:
  - Load 8, start, `stop` at cycle 3 for 4 cycles, then `start`.
  - `count` holds at 5, then `expired` arrives after 5 more RUN cycles.
  - `stop` coincident with `count`==1 holds 1 with no pulse.
- Clamp and zero:
  - Load 0xFFFF_FFFF reads back `count`=2147483647.
  - Load 0 with `periodic`=1, then start: one `expired` pulse, then DONE.
- Handshake:
  - `load_valid` during RUN is not accepted (`load_ready`=0).
  - Load with `start` in the same cycle from DONE goes to ARMED, not RUN, and `expire_count` clears.

Source files
------------

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with one-shot/periodic expiry and a saturating expiry counter.
// Latency: count = N on the edge that accepts start; expired is high for the cycle after edge start+N.
// Backpressure: load_ready is low in RUN, so a load offered then waits until the timer stops or finishes.
// Ports: clock/reset_n (async, active-low); load_valid/load_value/load_ready interval handshake;
//        start/stop/periodic level-sampled controls; count, expired, busy, expire_count status.
module countdown_timer #(
  parameter int unsigned     WIDTH     = 32,
  parameter longint unsigned MAX_VALUE = 2147483647,
  parameter int unsigned     EXP_CNT_W = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 load_valid,
  input  logic [WIDTH-1:0]     load_value,
  output logic                 load_ready,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 periodic,
  output logic [WIDTH-1:0]     count,
  output logic                 expired,
  output logic                 busy,
  output logic [EXP_CNT_W-1:0] expire_count
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VALUE);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_RUN    = 3'd2,
    S_PAUSED = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     count_q, count_d;
  logic [WIDTH-1:0]     reload_q, reload_d;
  logic                 mode_q, mode_d;
  logic                 expired_q, expired_d;
  logic [EXP_CNT_W-1:0] expire_count_q, expire_count_d;
  logic                 load_fire;
  logic [WIDTH-1:0]     load_clamped;

  assign load_ready   = (state_q != S_RUN);
  assign busy         = (state_q == S_RUN);
  assign load_fire    = load_valid && load_ready;
  assign load_clamped = (load_value > MAX_V) ? MAX_V : load_value;

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    reload_d       = reload_q;
    mode_d         = mode_q;
    expired_d      = 1'b0;
    expire_count_d = expire_count_q;

    if (load_fire) begin
      // A load always wins; a start in the same cycle is dropped.
      reload_d       = load_clamped;
      count_d        = load_clamped;
      expire_count_d = '0;
      state_d        = S_ARMED;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_ARMED, S_DONE: begin
          if (start) begin
            count_d = reload_q;
            mode_d  = periodic;
            state_d = S_RUN;
          end
        end
        S_PAUSED: begin
          if (start) begin
            mode_d  = periodic;
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (stop) begin
            state_d = S_PAUSED;
          end else if (count_q > WIDTH'(1)) begin
            count_d = count_q - WIDTH'(1);
          end else begin
            // count of 1 is a normal expiry; 0 only happens for a zero interval,
            // which can never reload, so it always finishes.
            expired_d = 1'b1;
            if (expire_count_q != '1) begin
              expire_count_d = expire_count_q + EXP_CNT_W'(1);
            end
            if (mode_q && (count_q == WIDTH'(1))) begin
              count_d = reload_q;
            end else begin
              count_d = '0;
              state_d = S_DONE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      count_q        <= '0;
      reload_q       <= '0;
      mode_q         <= 1'b0;
      expired_q      <= 1'b0;
      expire_count_q <= '0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      reload_q       <= reload_d;
      mode_q         <= mode_d;
      expired_q      <= expired_d;
      expire_count_q <= expire_count_d;
    end
  end

  assign count        = count_q;
  assign expired      = expired_q;
  assign expire_count = expire_count_q;

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed stimulus for countdown_timer with an elapsed-time reference model.
// Inputs change on the falling edge; outputs are compared on every falling edge and at key points.
module tb_countdown_timer;

  localparam int          W       = 32;
  localparam int          EW      = 4;
  localparam int          EXP_MAX = (1 << EW) - 1;
  localparam logic [31:0] MAXV    = 32'h7FFF_FFFF;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          load_valid = 1'b0;
  logic [W-1:0]  load_value = '0;
  logic          load_ready;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          periodic = 1'b0;
  logic [W-1:0]  count;
  logic          expired;
  logic          busy;
  logic [EW-1:0] expire_count;

  int errors = 0;
  int checks = 0;

  countdown_timer #(.WIDTH(W), .MAX_VALUE(2147483647), .EXP_CNT_W(EW)) dut (
    .clock(clock), .reset_n(reset_n),
    .load_valid(load_valid), .load_value(load_value), .load_ready(load_ready),
    .start(start), .stop(stop), .periodic(periodic),
    .count(count), .expired(expired), .busy(busy), .expire_count(expire_count)
  );

  always #5 clock = ~clock;

  // Reference model: time is tracked as cycles elapsed in the current interval;
  // the visible count is whatever remains of the interval.
  localparam int P_IDLE = 0, P_ARMED = 1, P_RUN = 2, P_PAUSED = 3, P_DONE = 4;
  int          m_phase   = P_IDLE;
  logic [31:0] m_reload  = '0;
  logic [31:0] m_elapsed = '0;
  logic        m_mode    = 1'b0;
  logic        m_exp     = 1'b0;
  int          m_expcnt  = 0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_phase <= P_IDLE; m_reload <= '0; m_elapsed <= '0;
      m_mode <= 1'b0; m_exp <= 1'b0; m_expcnt <= 0;
    end else begin
      m_exp <= 1'b0;
      if (load_valid && m_phase != P_RUN) begin
        m_reload  <= (load_value > MAXV) ? MAXV : load_value;
        m_elapsed <= '0;
        m_expcnt  <= 0;
        m_phase   <= P_ARMED;
      end else if ((m_phase == P_ARMED || m_phase == P_DONE) && start) begin
        m_elapsed <= '0; m_mode <= periodic; m_phase <= P_RUN;
      end else if (m_phase == P_PAUSED && start) begin
        m_mode <= periodic; m_phase <= P_RUN;
      end else if (m_phase == P_RUN) begin
        if (stop) begin
          m_phase <= P_PAUSED;
        end else if (m_reload == 0 || m_elapsed + 1 >= m_reload) begin
          m_exp <= 1'b1;
          if (m_expcnt < EXP_MAX) m_expcnt <= m_expcnt + 1;
          if (m_mode && m_reload != 0) m_elapsed <= '0;
          else m_phase <= P_DONE;
        end else begin
          m_elapsed <= m_elapsed + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic [31:0] exp_count;
    exp_count = (m_phase == P_IDLE || m_phase == P_DONE) ? 32'd0 : (m_reload - m_elapsed);
    chk("m_count", count, exp_count);
    chk("m_expired", expired, m_exp);
    chk("m_busy", busy, m_phase == P_RUN);
    chk("m_load_ready", load_ready, m_phase != P_RUN);
    chk("m_expire_count", expire_count, m_expcnt);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      compare_model();
    end
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load_valid = 1'b1; load_value = v;
    tick(1);
    load_valid = 1'b0;
  endtask

  task automatic do_start(input logic p);
    start = 1'b1; periodic = p;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    logic [9:0] pulses;
    tick(2);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_load_ready", load_ready, 1);
    chk("rst_expired", expired, 0);
    chk("rst_expire_count", expire_count, 0);
    reset_n = 1'b1;

    // Start with nothing loaded is ignored.
    do_start(0);
    chk("idle_start_busy", busy, 0);

    // Asynchronous reset mid-count.
    do_load(10);
    do_start(0);
    tick(3);
    chk("midrst_pre_count", count, 7);
    #3 reset_n = 1'b0;
    #1;
    chk("midrst_count", count, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_load_ready", load_ready, 1);
    tick(2);
    reset_n = 1'b1;
    tick(15);
    chk("midrst_expire_count", expire_count, 0);

    // One-shot, interval 5.
    do_load(5);
    do_start(0);
    chk("os_start_count", count, 5);
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      chk("os_count", count, 5 - i);
      chk("os_expired", expired, (i == 5));
    end
    tick(1);
    chk("os_done_busy", busy, 0);
    chk("os_done_expcnt", expire_count, 1);
    chk("os_done_expired", expired, 0);

    // Periodic, interval 3, ten cycles.
    do_load(3);
    do_start(1);
    chk("per_start_count", count, 3);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      pulses[i] = expired;
    end
    chk("per_pulses", pulses, 10'h124);
    chk("per_count", count, 2);
    chk("per_expcnt", expire_count, 3);
    stop = 1'b1; tick(1); stop = 1'b0;
    chk("per_stop_busy", busy, 0);

    // Pause and resume, interval 8.
    do_load(8);
    do_start(0);
    tick(3);
    chk("pause_pre_count", count, 5);
    stop = 1'b1; tick(4); stop = 1'b0;
    chk("pause_hold_count", count, 5);
    chk("pause_busy", busy, 0);
    do_start(0);
    chk("resume_count", count, 5);
    pulses = '0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      pulses[i] = expired;
    end
    chk("resume_pulses", pulses, 10'h010);

    // Stop coincident with count == 1 suppresses the expiry.
    do_load(2);
    do_start(0);
    tick(1);
    stop = 1'b1; tick(1); stop = 1'b0;
    chk("stop1_count", count, 1);
    chk("stop1_expired", expired, 0);
    do_start(0);
    tick(1);
    chk("stop1_resume_expired", expired, 1);

    // Clamp; stop outside RUN is ignored.
    do_load(32'hFFFF_FFFF);
    chk("clamp_count", count, 32'h7FFF_FFFF);
    stop = 1'b1; tick(1); stop = 1'b0;
    chk("armed_stop_count", count, 32'h7FFF_FFFF);
    do_load(32'h7FFF_FFFE);
    chk("noclamp_count", count, 32'h7FFF_FFFE);

    // Zero interval in periodic mode: one pulse then DONE.
    do_load(0);
    do_start(1);
    chk("zero_busy", busy, 1);
    tick(1);
    chk("zero_expired", expired, 1);
    chk("zero_done_busy", busy, 0);
    tick(1);
    chk("zero_after_expired", expired, 0);

    // Handshake: no load during RUN; load+start from DONE arms only.
    do_load(4);
    do_start(0);
    load_valid = 1'b1; load_value = 9;
    #1 chk("run_load_ready", load_ready, 0);
    tick(2);
    chk("run_load_ignored_count", count, 2);
    load_valid = 1'b0;
    tick(3);
    chk("hs_done_expcnt", expire_count, 1);
    load_valid = 1'b1; load_value = 6; start = 1'b1;
    tick(1);
    load_valid = 1'b0; start = 1'b0;
    chk("hs_load_start_busy", busy, 0);
    chk("hs_load_start_count", count, 6);
    chk("hs_load_start_expcnt", expire_count, 0);

    // Expiry counter saturation with a one-cycle periodic interval.
    do_load(1);
    do_start(1);
    tick(20);
    chk("sat_expcnt", expire_count, EXP_MAX);
    chk("sat_expired", expired, 1);
    stop = 1'b1; tick(1); stop = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
